// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with a valid/ready handshake, stall and flush.
// Define PIPE_STAGE_SKID_EN to add a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 101
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    // Handshake: an entry moves on a cycle where valid & ready are both high at the
    // rising edge; a valid entry and its payload stay unchanged until it moves.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              accept;
    logic              emit;
    logic              load_main_in;

`ifdef PIPE_STAGE_SKID_EN
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              ready_q;
    logic              load_main_skid;
    logic              load_skid;

    assign in_ready = ready_q;
    assign count    = state;
`else
    assign in_ready = !out_valid || out_ready;
    assign count    = {1'b0, state == HALF};
`endif

    assign out_valid = (state != EMPTY);
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_comb begin
        next_state   = state;
        load_main_in = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
`endif
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    next_state   = HALF;
                end
            end
            HALF: begin
                if (accept && emit) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
`ifdef PIPE_STAGE_SKID_EN
                    load_skid  = 1'b1;
                    next_state = FULL;
`else
                    load_main_in = 1'b1;
`endif
                end else if (emit) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
`ifdef PIPE_STAGE_SKID_EN
                if (emit) begin
                    load_main_skid = 1'b1;
                    next_state     = HALF;
                end
`else
                next_state = EMPTY;
`endif
            end
            default: next_state = EMPTY;
        endcase
    end

    // Reset and flush both empty the stage and zero the stored payloads.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_ctrl <= '0;
            skid_data <= '0;
            ready_q   <= 1'b1;
`endif
        end else begin
            state <= next_state;
            if (load_main_in) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end
`ifdef PIPE_STAGE_SKID_EN
            else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
            ready_q <= (next_state != FULL);
`endif
        end
    end

endmodule
